// File: rtl/wb_dest_scoreboard_if.sv
// Bus bundle for the destination-register scoreboard.
//   master : issues/retires destinations and presents ID source registers,
//            observes stall, busy_mask, inflight and the sticky error flags.
//   slave  : the scoreboard itself.
interface wb_dest_scoreboard_if #(
  parameter int NREG  = 32,
  parameter int INF_W = 6
);
  localparam int AW = $clog2(NREG);

  logic             issue_valid;
  logic             issue_we;
  logic [AW-1:0]    issue_rd;
  logic             wb_valid;
  logic [AW-1:0]    wb_rd;
  logic             flush;
  logic [AW-1:0]    src_rs;
  logic [AW-1:0]    src_rt;
  logic             stall;
  logic [NREG-1:0]  busy_mask;
  logic [INF_W-1:0] inflight;
  logic             err_ovf;
  logic             err_unf;

  modport master (
    output issue_valid, issue_we, issue_rd, wb_valid, wb_rd, flush, src_rs, src_rt,
    input  stall, busy_mask, inflight, err_ovf, err_unf
  );

  modport slave (
    input  issue_valid, issue_we, issue_rd, wb_valid, wb_rd, flush, src_rs, src_rt,
    output stall, busy_mask, inflight, err_ovf, err_unf
  );
endinterface

// File: rtl/wb_dest_scoreboard.sv
// Destination-register scoreboard.
// Tracks outstanding register writes between ID issue and WB retire with a
// small saturating counter per architectural register, and stalls ID when a
// source register still has a write in flight.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    slave side of wb_dest_scoreboard_if (issue, retire, flush, sources
//          in; stall, busy_mask, inflight, err_ovf, err_unf out)

// One register's outstanding-write counter. inc/dec arrive already qualified
// for this register; simultaneous inc and dec cancel.
module wb_dest_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk) begin
    if (!rst_n || flush)                   cnt <= '0;
    else if (inc && !dec && cnt != MAX)    cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0)     cnt <= cnt - 1'b1;
  end
endmodule

module wb_dest_scoreboard #(
  parameter int NREG   = 32,
  parameter int CNT_W  = 2,
  parameter int WB_BYP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_dest_scoreboard_if.slave bus
);
  localparam int AW    = $clog2(NREG);
  localparam int INF_W = 6;
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [NREG-1:0][CNT_W-1:0] cnt;

  // Register 0 is hardwired and never tracked.
  logic issue_ok, wb_ok, same;
  assign issue_ok = bus.issue_valid & bus.issue_we & (bus.issue_rd != '0);
  assign wb_ok    = bus.wb_valid & (bus.wb_rd != '0);
  assign same     = issue_ok & wb_ok & (bus.issue_rd == bus.wb_rd);

  logic [CNT_W-1:0] cnt_i, cnt_w;
  assign cnt_i = cnt[bus.issue_rd];
  assign cnt_w = cnt[bus.wb_rd];

  // Effective counter moves and error events; a same-register pair is a no-op.
  logic inc_eff, dec_eff, ovf_ev, unf_ev;
  assign inc_eff = issue_ok & ~same & (cnt_i != MAX);
  assign ovf_ev  = issue_ok & ~same & (cnt_i == MAX);
  assign dec_eff = wb_ok & ~same & (cnt_w != '0);
  assign unf_ev  = wb_ok & ~same & (cnt_w == '0);

  assign cnt[0]           = '0;
  assign bus.busy_mask[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_reg
    wb_dest_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (bus.flush),
      .inc   (issue_ok & (bus.issue_rd == AW'(i))),
      .dec   (wb_ok & (bus.wb_rd == AW'(i))),
      .cnt   (cnt[i])
    );
    assign bus.busy_mask[i] = |cnt[i];
  end

  // inflight tracks the counter sum incrementally; it moves only when a
  // counter actually moves, so saturation/underflow leave it alone.
  // It is 6 bits wide and wraps if more than 63 writes are outstanding.
  logic [INF_W-1:0] inflight_q;
  logic             err_ovf_q, err_unf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q <= '0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
    end else if (bus.flush) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_q + INF_W'(inc_eff) - INF_W'(dec_eff);
      err_ovf_q  <= err_ovf_q | ovf_ev;
      err_unf_q  <= err_unf_q | unf_ev;
    end
  end

  assign bus.inflight = inflight_q;
  assign bus.err_ovf  = err_ovf_q;
  assign bus.err_unf  = err_unf_q;

  // Source hazard. A last outstanding write retiring this cycle is covered by
  // register-file write-through, so it need not stall.
  logic [CNT_W-1:0] cnt_rs, cnt_rt;
  logic             byp_rs, byp_rt, hit_rs, hit_rt;
  assign cnt_rs = cnt[bus.src_rs];
  assign cnt_rt = cnt[bus.src_rt];
  assign byp_rs = (WB_BYP != 0) & bus.wb_valid & (bus.wb_rd == bus.src_rs) & (cnt_rs == ONE);
  assign byp_rt = (WB_BYP != 0) & bus.wb_valid & (bus.wb_rd == bus.src_rt) & (cnt_rt == ONE);
  assign hit_rs = (bus.src_rs != '0) & (cnt_rs != '0) & ~byp_rs;
  assign hit_rt = (bus.src_rt != '0) & (cnt_rt != '0) & ~byp_rt;
  assign bus.stall = hit_rs | hit_rt;
endmodule

// File: tb/tb_wb_dest_scoreboard.sv
module tb_wb_dest_scoreboard;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_dest_scoreboard_if #(.NREG(32), .INF_W(6)) bus ();

  wb_dest_scoreboard #(.NREG(32), .CNT_W(2), .WB_BYP(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Expected observation; negative field = not checked.
  typedef struct {
    string  name;
    int     stall;
    longint busy;
    int     infl;
    int     ovf;
    int     unf;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic cmp(input string nm, input string fld, input longint act, input longint exp);
    if (exp < 0) return;
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, exp);
    end
  endtask

  // Monitor: checks every pending expectation against the outputs of the
  // current cycle, mid-cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.name, "stall",     longint'(bus.stall),     longint'(e.stall));
      cmp(e.name, "busy_mask", longint'(bus.busy_mask), e.busy);
      cmp(e.name, "inflight",  longint'(bus.inflight),  longint'(e.infl));
      cmp(e.name, "err_ovf",   longint'(bus.err_ovf),   longint'(e.ovf));
      cmp(e.name, "err_unf",   longint'(bus.err_unf),   longint'(e.unf));
    end
  end

  task automatic ex(input string nm, input int st, input longint bm, input int inf,
                    input int ov, input int un);
    exp_t e;
    e.name = nm; e.stall = st; e.busy = bm; e.infl = inf; e.ovf = ov; e.unf = un;
    q.push_back(e);
  endtask

  task automatic drive(input logic iv, input logic we, input logic [4:0] ird,
                       input logic wv, input logic [4:0] wrd, input logic fl,
                       input logic [4:0] rs, input logic [4:0] rt);
    bus.issue_valid = iv; bus.issue_we = we; bus.issue_rd = ird;
    bus.wb_valid = wv; bus.wb_rd = wrd; bus.flush = fl;
    bus.src_rs = rs; bus.src_rt = rt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;
    ex("reset", 0, 0, 0, 0, 0);
    tick();

    // issue rd8; the issuing instruction must not stall itself
    drive(1, 1, 8, 0, 0, 0, 8, 0); ex("issue_no_self_stall", 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 8, 0); ex("rs8_busy", 1, 'h100, 1, 0, 0);        tick();
    drive(0, 0, 0, 1, 8, 0, 8, 0); ex("wb_bypass", 0, 'h100, 1, 0, 0);       tick();
    drive(0, 0, 0, 0, 0, 0, 8, 0); ex("rd8_drained", 0, 0, 0, 0, 0);         tick();

    // issue without RegWrite is ignored
    drive(1, 0, 6, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 6); ex("we0_ignored", 0, 0, 0, 0, 0); tick();

    // same-cycle issue+retire to one register, from cnt=1 and from cnt=0
    drive(1, 1, 9, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 9, 1, 9, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 9, 0); ex("same_cycle_cnt1", 1, 'h200, 1, 0, 0); tick();
    drive(1, 1, 11, 1, 11, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 11); ex("same_cycle_cnt0", 0, 'h200, 1, 0, 0); tick();
    drive(0, 0, 0, 1, 9, 0, 0, 0); tick();

    // register 0 is never tracked
    drive(1, 1, 0, 1, 0, 0, 0, 0); ex("r0_pair", 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); ex("r0_ignored", 0, 0, 0, 0, 0); tick();

    // saturate rd5, then overflow
    repeat (3) begin drive(1, 1, 5, 0, 0, 0, 0, 0); tick(); end
    drive(0, 0, 0, 0, 0, 0, 0, 5); ex("cnt5_sat", 1, 'h20, 3, 0, 0); tick();
    drive(1, 1, 5, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); ex("ovf", 0, 'h20, 3, 1, 0); tick();

    // retire rd5 four times; bypass must not apply while cnt>1
    drive(0, 0, 0, 1, 5, 0, 5, 0); ex("no_byp_cnt3", 1, 'h20, 3, 1, 0); tick();
    drive(0, 0, 0, 1, 5, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 5, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 5, 0); ex("drained5", 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 1, 5, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); ex("unf", 0, 0, 0, 1, 1); tick();

    // outstanding 3,4,7 then flush beating an issue to rd10
    drive(1, 1, 3, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 4, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 7, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 3, 0); ex("three_out", 1, 'h98, 3, 1, 1); tick();
    drive(1, 1, 10, 0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 10, 7); ex("flush", 0, 0, 0, 1, 1); tick();

    // mid-operation reset clears everything in one cycle
    drive(1, 1, 12, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); rst_n = 1'b0; tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 12, 0); ex("mid_reset", 0, 0, 0, 0, 0); tick();

    repeat (2) tick();
    cmp("end", "queue_left", longint'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
